// File: rtl/des_oversample.sv
// des_oversample: oversampling serial-to-parallel deserializer.
// Picks one sample per bit at sample_phase (0..OSR-1), assembles DATA_W-bit
// words LSB-first and flags each completed word with a one-cycle data_valid.
// Optional word alignment is enabled by defining DES_ALIGN_EN: the block then
// hunts for SYNC_WORD before framing, and locked reports the alignment state.
module des_oversample #(
  parameter int unsigned              DATA_W    = 8,
  parameter int unsigned              OSR       = 4,
  parameter logic [DATA_W-1:0]        SYNC_WORD = 8'hBC,
  localparam int unsigned             PH_W      = $clog2(OSR)
) (
  input  logic              clock_160,
  input  logic              reset,
  input  logic              enable,
  input  logic              restart,
  input  logic [PH_W-1:0]   sample_phase,
  input  logic              data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              locked
);

  localparam int unsigned BC_W = $clog2(DATA_W);

  logic [PH_W-1:0]   samp_cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic [DATA_W-1:0] shifter;
  logic [DATA_W-1:0] candidate;
  logic              strobe;
  logic              last_bit;

  // Sample strobe and the word as it would look after this strobe's shift.
  always_comb begin
    strobe    = enable && (samp_cnt == sample_phase);
    candidate = {data_in, shifter[DATA_W-1:1]};
    last_bit  = (bit_cnt == BC_W'(DATA_W - 1));
  end

`ifdef DES_ALIGN_EN
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t state;

  assign locked = (state == LOCKED);

  // Counters, shifter, output word and the HUNT/LOCKED alignment FSM.
  always_ff @(posedge clock_160) begin
    if (reset) begin
      samp_cnt   <= '0;
      bit_cnt    <= '0;
      shifter    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      state      <= HUNT;
    end else if (restart) begin
      samp_cnt   <= '0;
      bit_cnt    <= '0;
      shifter    <= '0;
      data_valid <= 1'b0;
      state      <= HUNT;
    end else begin
      data_valid <= 1'b0;
      if (enable) begin
        samp_cnt <= (samp_cnt == PH_W'(OSR - 1)) ? '0 : samp_cnt + 1'b1;
      end
      if (strobe) begin
        shifter <= candidate;
        case (state)
          HUNT: begin
            // bit_cnt is meaningless until the sync word has been seen.
            if (candidate == SYNC_WORD) begin
              state   <= LOCKED;
              bit_cnt <= '0;
            end
          end
          LOCKED: begin
            if (last_bit) begin
              data_out   <= candidate;
              data_valid <= 1'b1;
              bit_cnt    <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end
`else
  assign locked = 1'b1;

  // Counters, shifter and output word; framing starts at bit_cnt=0.
  always_ff @(posedge clock_160) begin
    if (reset) begin
      samp_cnt   <= '0;
      bit_cnt    <= '0;
      shifter    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (restart) begin
      samp_cnt   <= '0;
      bit_cnt    <= '0;
      shifter    <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (enable) begin
        samp_cnt <= (samp_cnt == PH_W'(OSR - 1)) ? '0 : samp_cnt + 1'b1;
      end
      if (strobe) begin
        shifter <= candidate;
        if (last_bit) begin
          data_out   <= candidate;
          data_valid <= 1'b1;
          bit_cnt    <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: doc/des_oversample.md
Name: des_oversample

Overview:
Parametrised oversampling serial-to-parallel deserializer running on clock_160. It takes one serial line sampled OSR times per bit and picks one sample per bit at a programmable phase. It assembles DATA_W-bit words LSB-first and presents each completed word with a one-cycle valid strobe. It is the generalised successor to the fixed 8-bit, 4x-oversampled deserializer and sits between the serial front end and word-level framing logic.

Parameters:
DATA_W, 8, word width in bits (>=2)
OSR, 4, clocks per serial bit (>=2)
SYNC_WORD, 8'hBC (DATA_W bits), alignment word; used only when DES_ALIGN_EN is defined
PH_W, $clog2(OSR), width of sample_phase (derived localparam, not overridable)

Ports:
clock_160  in  1  deserializer clock, all logic on rising edge
reset  in  1  synchronous, active-high
enable  in  1  advance counters and sampling when high; freeze all state when low
restart  in  1  synchronous re-frame: clears counters and shifter, keeps data_out
sample_phase  in  PH_W  oversample index (0..OSR-1) at which the bit is captured
data_in  in  1  serial input, OSR clocks per bit
data_out  out  DATA_W  last completed word
data_valid  out  1  one-cycle pulse, data_out updated this cycle
locked  out  1  framing established (constant 1 without DES_ALIGN_EN)

Behaviour:
- Reset (synchronous, active-high, clock clock_160): samp_cnt=0, bit_cnt=0, shifter=0, data_out=0, data_valid=0, state=HUNT (with macro).
- Reset and restart take priority over enable. Reset has priority over restart.
- samp_cnt: counts 0..OSR-1 and wraps to 0 on each enabled cycle.
- Sample strobe: asserted when enable=1 and samp_cnt==sample_phase.
- sample_phase >= OSR: no strobe ever fires. No words are produced. No error output.
- On a strobe, the shifter takes {data_in, shifter[DATA_W-1:1]}. The first received bit ends up in data_out[0].
- bit_cnt: counts strobes 0..DATA_W-1.
- On the strobe with bit_cnt==DATA_W-1:
  - data_out <= {data_in, shifter[DATA_W-1:1]}, visible on the next edge.
  - data_valid=1 for exactly that one following cycle.
  - bit_cnt wraps to 0 and the shifter is not cleared.
- Latency: data_valid rises 1 clock after the last bit's sampling edge.
- Back-to-back words produce valid pulses exactly DATA_W*OSR enabled cycles apart.
- enable=0:
  - samp_cnt, bit_cnt, shifter and state hold.
  - data_valid=0 and data_out holds.
  - A word spanning an enable gap completes correctly, delayed by the gap length.
- restart=1:
  - samp_cnt, bit_cnt and shifter are cleared to 0, and data_valid=0.
  - data_out holds; with the macro, state returns to HUNT.
  - The next cycle with enable=1 is oversample index 0 of a new bit.
- Reset mid-word: the partial word is discarded and no valid pulse is produced for it.
- data_valid is never asserted during reset or restart cycles.

Optional Feature:
DES_ALIGN_EN
- Defined: two-state FSM, HUNT and LOCKED.
  - HUNT: every strobe shifts into the shifter and bit_cnt is ignored. When the candidate {data_in, shifter[DATA_W-1:1]} == SYNC_WORD, go to LOCKED and set bit_cnt=0. No data_valid is produced for the sync word.
  - LOCKED: normal framing as above. locked=1 only in LOCKED.
  - restart or reset returns to HUNT with locked=0. No automatic loss-of-lock.
- Not defined: no FSM and locked is tied to 1. Framing starts at bit_cnt=0 after reset or restart.

Test Plan:
1. DATA_W=8, OSR=4, phase=3; after reset, enable=1 and send 0xA5 LSB-first with each bit held 4 clocks -> strobes at enabled cycles 3,7,...,31; data_valid single pulse at cycle 32 with data_out=8'hA5.
2. Send 0x3C then 0xC3 back-to-back -> two valid pulses 32 cycles apart, data_out 8'h3C then 8'hC3, data_valid low in between.
3. Same as 1 with enable deasserted for 5 cycles after bit 3 -> data_out=8'hA5 with the valid pulse at cycle 37; no glitch pulse during the gap.
4. Assert reset at cycle 15 of a word, then send 0x5A -> data_out=0 and data_valid=0 immediately; the next pulse carries 8'h5A, framed from the first enabled cycle after reset.
5. phase=0 versus phase=3 with data_in toggled on the last oversample of each bit -> phase=0 captures the intended 0x96; restart mid-word clears the partial word and data_out keeps the previous value.
6. DES_ALIGN_EN, SYNC_WORD=0xBC: 3 garbage bits, then 0xBC, then 0x42 -> locked rises on the sync strobe's following edge, no valid for 0xBC, next valid has data_out=8'h42; restart drops locked to 0.
